// File: rtl/cic_sched_pkg.sv
// cic_sched_pkg: shared types and constants for the CIC channel scheduler.
//   sched_state_t  - scheduler FSM states (IDLE / START / WAIT)
//   DEF_*          - default parameter values used by cic_chan_sched
//   clog2_min1()   - ceil(log2(n)) clamped to at least 1, for index widths
package cic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_IN_WIDTH  = 28;
  localparam int DEF_OUT_WIDTH = 24;
  localparam int DEF_TIMEOUT   = 255;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cic_chan_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   req       in   NUM_CH  request vector
//   rr_ptr    in   CW      highest-priority channel this round
//   any_req   out  1       at least one request present
//   grant     out  NUM_CH  one-hot grant (all zero when no request)
//   grant_idx out  CW      encoded index of the granted channel
module rr_arbiter
  import cic_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CW    = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     rr_ptr,
  output logic              any_req,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_idx
);

  logic          hi_hit;
  logic [CW-1:0] hi_idx;
  logic          lo_hit;
  logic [CW-1:0] lo_idx;

  // Scanning downward lets the lowest matching index overwrite the others.
  // hi_* is the first request at or after rr_ptr; lo_* is the wrap-around
  // fallback (first request overall).
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = CW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_hit = 1'b1;
          hi_idx = CW'(i);
        end
      end
    end
    any_req   = lo_hit;
    grant_idx = hi_hit ? hi_idx : lo_idx;
    grant     = lo_hit ? (NUM_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cic_chan_sched.sv
// cic_chan_sched: shares one RAM-based CIC engine between NUM_CH channels.
// Latches per-channel strobes into hold registers, grants the engine
// round-robin, issues one start pulse per pass and tags engine outputs with
// the owning channel.
//   clk, rst            clock, synchronous active-high reset
//   req_strobe/req_data per-channel sample pulse and packed samples
//   eng_start/eng_ch/eng_data  engine start pulse, bank select, sample
//   eng_done            engine pass complete
//   eng_out_strobe/eng_out_data  raw engine output
//   out_strobe/out_ch/out_data   channel-tagged output (1 cycle later)
//   overrun/clr_overrun sticky per-channel overrun flags and their clear
//   timeout_err         sticky watchdog flag
// Optional feature: define CIC_SCHED_TIMEOUT_EN to enable the pass watchdog.
module cic_chan_sched
  import cic_sched_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int CW       = clog2_min1(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_strobe,
  input  logic [NUM_CH*IN_WIDTH-1:0] req_data,
  output logic                       eng_start,
  output logic [CW-1:0]              eng_ch,
  output logic [IN_WIDTH-1:0]        eng_data,
  input  logic                       eng_done,
  input  logic                       eng_out_strobe,
  input  logic [OUT_WIDTH-1:0]       eng_out_data,
  output logic                       out_strobe,
  output logic [CW-1:0]              out_ch,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [NUM_CH-1:0]          overrun,
  input  logic                       clr_overrun,
  output logic                       timeout_err
);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT < 1) begin : g_param_check
    $error("cic_chan_sched: unsupported NUM_CH or TIMEOUT");
  end

  sched_state_t state_reg, state_next;

  // Input capture stage: strobes are registered once before they reach the
  // pending/hold logic, which sets the two-cycle idle start latency.
  logic [NUM_CH-1:0]          stb_q_reg;
  logic [NUM_CH*IN_WIDTH-1:0] data_q_reg;

  logic [IN_WIDTH-1:0]  hold_vals [NUM_CH];
  logic [NUM_CH-1:0]    pending_reg, pending_next;
  logic [NUM_CH-1:0]    overrun_reg, overrun_next;
  logic [NUM_CH-1:0]    ovr_set;
  logic [CW-1:0]        rr_ptr_reg;
  logic [CW-1:0]        eng_ch_reg;
  logic [IN_WIDTH-1:0]  eng_data_reg;
  logic                 eng_start_reg;
  logic                 out_strobe_reg;
  logic [CW-1:0]        out_ch_reg;
  logic [OUT_WIDTH-1:0] out_data_reg;

  logic              any_req;
  logic [NUM_CH-1:0] grant_vec;
  logic [CW-1:0]     grant_idx;
  logic              grant_fire;
  logic [NUM_CH-1:0] grant_mask;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (pending_reg),
    .rr_ptr    (rr_ptr_reg),
    .any_req   (any_req),
    .grant     (grant_vec),
    .grant_idx (grant_idx)
  );

`ifdef CIC_SCHED_TIMEOUT_EN
  localparam int TW = clog2_min1(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt_reg;
  logic          timeout_hit;
  logic          timeout_err_reg;
`endif

  always_comb begin
    state_next = state_reg;
    grant_fire = 1'b0;
`ifdef CIC_SCHED_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_fire = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          state_next = IDLE;
`ifdef CIC_SCHED_TIMEOUT_EN
        end else if (wd_cnt_reg == TW'(TIMEOUT - 1)) begin
          // The granted sample is abandoned; the engine is presumed hung.
          timeout_hit = 1'b1;
          state_next  = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A strobe on the channel granted this cycle re-arms pending without
  // counting as an overrun: the old sample has just been consumed.
  always_comb begin
    grant_mask   = grant_fire ? grant_vec : '0;
    ovr_set      = stb_q_reg & pending_reg & ~grant_mask;
    pending_next = (pending_reg & ~grant_mask) | stb_q_reg;
    overrun_next = (clr_overrun ? '0 : overrun_reg) | ovr_set;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [IN_WIDTH-1:0] hold_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_reg <= '0;
      end else if (stb_q_reg[gi]) begin
        hold_reg <= data_q_reg[gi*IN_WIDTH +: IN_WIDTH];
      end
    end
    assign hold_vals[gi] = hold_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      stb_q_reg      <= '0;
      data_q_reg     <= '0;
      pending_reg    <= '0;
      overrun_reg    <= '0;
      rr_ptr_reg     <= '0;
      eng_ch_reg     <= '0;
      eng_data_reg   <= '0;
      eng_start_reg  <= 1'b0;
      out_strobe_reg <= 1'b0;
      out_ch_reg     <= '0;
      out_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      stb_q_reg     <= req_strobe;
      data_q_reg    <= req_data;
      pending_reg   <= pending_next;
      overrun_reg   <= overrun_next;
      eng_start_reg <= (state_next == START);
      if (grant_fire) begin
        eng_ch_reg   <= grant_idx;
        eng_data_reg <= hold_vals[grant_idx];
        rr_ptr_reg   <= (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + CW'(1);
      end
      // Tag with the channel held before this edge, so an output arriving
      // together with eng_done still belongs to the finishing pass.
      out_strobe_reg <= eng_out_strobe;
      if (eng_out_strobe) begin
        out_ch_reg   <= eng_ch_reg;
        out_data_reg <= eng_out_data;
      end
    end
  end

`ifdef CIC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == WAIT) ? wd_cnt_reg + TW'(1) : '0;
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign eng_start  = eng_start_reg;
  assign eng_ch     = eng_ch_reg;
  assign eng_data   = eng_data_reg;
  assign out_strobe = out_strobe_reg;
  assign out_ch     = out_ch_reg;
  assign out_data   = out_data_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_cic_chan_sched.sv
// tb_cic_chan_sched: table-driven single-channel check, directed sequences for
// arbitration order, overrun, same-cycle grant/strobe, reset mid-pass and the
// optional watchdog, then randomized traffic against a reference model.
module tb_cic_chan_sched;
  localparam int N  = 4;
  localparam int IW = 28;
  localparam int OW = 24;
  localparam int TO = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [N-1:0]      req_strobe = '0;
  logic [N*IW-1:0]   req_data = '0;
  logic              eng_start;
  logic [CW-1:0]     eng_ch;
  logic [IW-1:0]     eng_data;
  logic              eng_done = 1'b0;
  logic              eng_out_strobe = 1'b0;
  logic [OW-1:0]     eng_out_data = '0;
  logic              out_strobe;
  logic [CW-1:0]     out_ch;
  logic [OW-1:0]     out_data;
  logic [N-1:0]      overrun;
  logic              clr_overrun = 1'b0;
  logic              timeout_err;

  cic_chan_sched #(.NUM_CH(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_strobe(req_strobe), .req_data(req_data),
    .eng_start(eng_start), .eng_ch(eng_ch), .eng_data(eng_data),
    .eng_done(eng_done), .eng_out_strobe(eng_out_strobe), .eng_out_data(eng_out_data),
    .out_strobe(out_strobe), .out_ch(out_ch), .out_data(out_data),
    .overrun(overrun), .clr_overrun(clr_overrun), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (rule level) ----------------
  typedef struct { logic [N-1:0] stb; logic [N*IW-1:0] d; } req_t;
  req_t          m_q[$];          // one-cycle input capture delay
  bit            m_pend[N];
  logic [IW-1:0] m_hold[N];
  bit            m_ovr[N];
  int            m_ptr, m_mode, m_wait;   // mode: 0 free, 1 started, 2 busy
  bit            m_terr, m_start, m_ostb;
  int            m_ch, m_och;
  logic [IW-1:0] m_data;
  logic [OW-1:0] m_odata;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_hold[i] = '0; m_ovr[i] = 0;
    end
    m_ptr = 0; m_mode = 0; m_wait = 0; m_terr = 0; m_start = 0; m_ostb = 0;
    m_ch = 0; m_och = 0; m_data = '0; m_odata = '0;
    m_q.delete();
    m_q.push_back('{stb: '0, d: '0});
  endtask

  task automatic model_edge();
    req_t r;
    int   granted;
    bit   sets[N];
    if (rst) begin
      model_reset();
      return;
    end
    m_ostb = eng_out_strobe;
    if (eng_out_strobe) begin
      m_och = m_ch; m_odata = eng_out_data;
    end
    granted = -1;
    m_start = 0;
    case (m_mode)
      0: begin
        for (int k = 0; k < N; k++) begin
          if (granted < 0 && m_pend[(m_ptr + k) % N]) granted = (m_ptr + k) % N;
        end
        if (granted >= 0) begin
          m_ch = granted; m_data = m_hold[granted]; m_pend[granted] = 0;
          m_ptr = (granted + 1) % N; m_mode = 1; m_start = 1;
        end
      end
      1: begin m_mode = 2; m_wait = 0; end
      default: begin
        if (eng_done) m_mode = 0;
`ifdef CIC_SCHED_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin m_mode = 0; m_terr = 1; end
        end
`endif
      end
    endcase
    r = m_q.pop_front();
    m_q.push_back('{stb: req_strobe, d: req_data});
    for (int i = 0; i < N; i++) begin
      sets[i] = r.stb[i] && m_pend[i] && (i != granted);
      if (clr_overrun) m_ovr[i] = 0;
      if (sets[i]) m_ovr[i] = 1;
      if (r.stb[i]) begin
        m_hold[i] = r.d[i*IW +: IW]; m_pend[i] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ov;
    for (int i = 0; i < N; i++) ov[i] = m_ovr[i];
    chk("eng_start",   32'(eng_start),   32'(m_start));
    chk("eng_ch",      32'(eng_ch),      32'(m_ch));
    chk("eng_data",    32'(eng_data),    32'(m_data));
    chk("out_strobe",  32'(out_strobe),  32'(m_ostb));
    chk("out_ch",      32'(out_ch),      32'(m_och));
    chk("out_data",    32'(out_data),    32'(m_odata));
    chk("overrun",     32'(overrun),     32'(ov));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // ---------------- engine stimulus ----------------
  bit            e_auto = 0, e_hang = 0, e_rand_ostb = 0;
  int            e_cnt = 0, e_lat_min = 2, e_lat_max = 2;
  int            grants[$];
  logic [IW-1:0] gdata[$];

  task automatic tick();
    if (e_auto) begin
      eng_done = 0; eng_out_strobe = 0; eng_out_data = OW'($urandom);
      if (e_cnt == 1) begin
        eng_done = 1; eng_out_strobe = 1;
      end else if (e_rand_ostb && $urandom_range(0, 7) == 0) begin
        eng_out_strobe = 1;
      end
      if (e_cnt > 0) e_cnt--;
    end
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (rst) e_cnt = 0;
    if (eng_start) begin
      grants.push_back(int'(eng_ch)); gdata.push_back(eng_data);
      if (e_auto && !e_hang) e_cnt = $urandom_range(e_lat_min, e_lat_max);
    end
    req_strobe = '0; clr_overrun = 0;
    if (!e_auto) begin eng_done = 0; eng_out_strobe = 0; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
    grants.delete(); gdata.delete();
  endtask

  task automatic strobe_ch(input int c, input logic [IW-1:0] d);
    req_strobe[c] = 1'b1;
    req_data[c*IW +: IW] = d;
  endtask

  task automatic chk_grants(input string name, input int exp[]);
    chk({name, "_count"}, 32'(grants.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  typedef struct {
    logic [N-1:0]  stb; logic [IW-1:0] d; logic done; logic ostb; logic [OW-1:0] odata;
    logic x_start; logic [CW-1:0] x_ch; logic [IW-1:0] x_data;
    logic x_ostb; logic [CW-1:0] x_och; logic [OW-1:0] x_odata;
  } vec_t;

  initial begin
    vec_t tbl[6];
    tbl[0] = '{4'b0100, 28'h0000123, 0, 0, 24'h0, 0, 2'd0, 28'h0,   0, 2'd0, 24'h0};
    tbl[1] = '{4'b0000, 28'h0,       0, 0, 24'h0, 0, 2'd0, 28'h0,   0, 2'd0, 24'h0};
    tbl[2] = '{4'b0000, 28'h0,       0, 0, 24'h0, 1, 2'd2, 28'h123, 0, 2'd0, 24'h0};
    tbl[3] = '{4'b0000, 28'h0,       0, 0, 24'h0, 0, 2'd2, 28'h123, 0, 2'd0, 24'h0};
    tbl[4] = '{4'b0000, 28'h0,       1, 1, 24'hABCDEF, 0, 2'd2, 28'h123, 1, 2'd2, 24'hABCDEF};
    tbl[5] = '{4'b0000, 28'h0,       0, 0, 24'h0, 0, 2'd2, 28'h123, 0, 2'd2, 24'hABCDEF};

    // Table: single channel, 2-cycle start latency, 1-cycle output tag.
    do_reset();
    e_auto = 0;
    for (int v = 0; v < 6; v++) begin
      req_strobe = tbl[v].stb;
      req_data = '0;
      req_data[2*IW +: IW] = tbl[v].d;
      eng_done = tbl[v].done; eng_out_strobe = tbl[v].ostb; eng_out_data = tbl[v].odata;
      tick();
      chk($sformatf("tbl%0d_eng_start", v), 32'(eng_start), 32'(tbl[v].x_start));
      chk($sformatf("tbl%0d_eng_ch", v),    32'(eng_ch),    32'(tbl[v].x_ch));
      chk($sformatf("tbl%0d_eng_data", v),  32'(eng_data),  32'(tbl[v].x_data));
      chk($sformatf("tbl%0d_out_strobe", v), 32'(out_strobe), 32'(tbl[v].x_ostb));
      chk($sformatf("tbl%0d_out_ch", v),    32'(out_ch),    32'(tbl[v].x_och));
      chk($sformatf("tbl%0d_out_data", v),  32'(out_data),  32'(tbl[v].x_odata));
    end
    $display("seq table single-channel done");

    // Round-robin order from rr_ptr=0, then from rr_ptr=1.
    e_auto = 1; e_lat_min = 2; e_lat_max = 2; e_rand_ostb = 0;
    do_reset();
    for (int c = 0; c < N; c++) strobe_ch(c, IW'(28'h100 + c));
    run(30);
    chk_grants("rr_order0", '{0, 1, 2, 3});
    grants.delete();
    strobe_ch(0, 28'h55); run(10);
    for (int c = 0; c < N; c++) strobe_ch(c, IW'(28'h200 + c));
    run(30);
    chk_grants("rr_order1", '{0, 1, 2, 3, 0});
    $display("seq round-robin done");

    // Overrun: ch1 strobes twice during a long pass on ch0.
    do_reset();
    e_lat_min = 30; e_lat_max = 30;
    strobe_ch(0, 28'h7); run(4);
    e_lat_min = 3; e_lat_max = 3;
    strobe_ch(1, 28'h11); run(3);
    strobe_ch(1, 28'h22); run(3);
    chk("overrun_set", 32'(overrun), 32'h2);
    run(40);
    chk_grants("ovr_order", '{0, 1});
    chk("ovr_newest_data", (gdata.size() > 1) ? 32'(gdata[1]) : 32'hFFFF_FFFF, 32'h22);
    clr_overrun = 1; tick();
    chk("overrun_clr", 32'(overrun), 32'h0);
    $display("seq overrun done");

    // Strobe on the channel being granted in the same cycle.
    do_reset();
    strobe_ch(3, 28'h31); tick();
    strobe_ch(3, 28'h32); tick();
    run(20);
    chk_grants("same_cycle_order", '{3, 3});
    chk("same_cycle_old", (gdata.size() > 0) ? 32'(gdata[0]) : 32'hFFFF_FFFF, 32'h31);
    chk("same_cycle_new", (gdata.size() > 1) ? 32'(gdata[1]) : 32'hFFFF_FFFF, 32'h32);
    chk("same_cycle_no_ovr", 32'(overrun), 32'h0);
    $display("seq same-cycle grant done");

    // Reset during WAIT with three channels pending.
    do_reset();
    strobe_ch(2, 28'h2A); run(8);
    e_lat_min = 30; e_lat_max = 30;
    strobe_ch(1, 28'h1B); run(4);
    strobe_ch(0, 28'h3); strobe_ch(2, 28'h4); strobe_ch(3, 28'h5); run(3);
    rst = 1; tick(); rst = 0;
    chk("rst_eng_start", 32'(eng_start), 32'h0);
    chk("rst_eng_ch", 32'(eng_ch), 32'h0);
    chk("rst_eng_data", 32'(eng_data), 32'h0);
    chk("rst_out", 32'({out_strobe, out_ch, out_data}), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    grants.delete();
    run(20);
    chk("rst_no_start", 32'(grants.size()), 32'h0);
    $display("seq reset mid-pass done");

`ifdef CIC_SCHED_TIMEOUT_EN
    // Hung engine: watchdog returns to IDLE and the next channel starts.
    do_reset();
    e_hang = 1;
    strobe_ch(0, 28'hA0); strobe_ch(1, 28'hA1); run(2 + 2 + TO + 4);
    chk("timeout_err", 32'(timeout_err), 32'h1);
    chk("timeout_next_ch", (grants.size() > 1) ? 32'(grants[1]) : 32'hFFFF_FFFF, 32'h1);
    e_hang = 0;
    $display("seq watchdog done");
`endif

    // Randomized traffic against the model.
    do_reset();
    e_lat_min = 2; e_lat_max = 8; e_rand_ostb = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) strobe_ch(c, IW'($urandom));
      clr_overrun = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      rst = 0;
    end
    $display("seq random done, starts=%0d", grants.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
